// File: rtl/mem_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter_if
//   Bundles the three buses around the unified memory-port arbiter:
//     - the fetch requester   (if_req / if_addr / if_rdata / if_valid)
//     - the data requester    (dm_req / dm_we / dm_be / dm_addr / dm_wdata /
//                              dm_rdata / dm_valid)
//     - the memory port       (mem_req / mem_we / mem_be / mem_addr /
//                              mem_wdata / mem_gnt / mem_rvalid / mem_rdata)
//     - the hazard-unit stalls (stall_if / stall_dm)
//   Modports:
//     master : the arbiter's view (masters the memory port, answers the
//              requesters)
//     slave  : the surrounding pipeline and memory's view
// ---------------------------------------------------------------------------
interface mem_port_arbiter_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_valid;

    logic        dm_req;
    logic        dm_we;
    logic [3:0]  dm_be;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;
    logic        dm_valid;

    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    logic        stall_if;
    logic        stall_dm;

    modport master (
        input  if_req, if_addr,
        output if_rdata, if_valid,
        input  dm_req, dm_we, dm_be, dm_addr, dm_wdata,
        output dm_rdata, dm_valid,
        output mem_req, mem_we, mem_be, mem_addr, mem_wdata,
        input  mem_gnt, mem_rvalid, mem_rdata,
        output stall_if, stall_dm
    );

    modport slave (
        output if_req, if_addr,
        input  if_rdata, if_valid,
        output dm_req, dm_we, dm_be, dm_addr, dm_wdata,
        input  dm_rdata, dm_valid,
        input  mem_req, mem_we, mem_be, mem_addr, mem_wdata,
        output mem_gnt, mem_rvalid, mem_rdata,
        input  stall_if, stall_dm
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//   Shares one memory port between instruction fetch (IF) and data memory
//   (DM). One transaction at a time walks IDLE -> ADDR -> DATA -> RESP:
//     IDLE : arbitrate; DM wins unless IF has been passed over STARVE_LIMIT
//            times in a row, then latch the winner's request.
//     ADDR : mem_req high with stable address/control until mem_gnt.
//     DATA : wait for mem_rvalid, capture mem_rdata for the owner.
//     RESP : one-cycle valid pulse to the owner; never arbitrates.
//   stall_if / stall_dm are combinational (req & ~valid) for the hazard unit.
//
// Ports:
//   clk          core clock
//   rst          synchronous active-high reset
//   bus          mem_port_arbiter_if.master (requester, memory, stall signals)
//   mem_timeout  (only with MEM_ARB_TIMEOUT_EN) sticky flag, set when a
//                transaction is aborted after TIMEOUT_CYCLES in ADDR+DATA
//
// Parameters:
//   STARVE_LIMIT    consecutive DM grants tolerated while IF waits (1..15)
//   TIMEOUT_CYCLES  ADDR+DATA cycle budget (used only with MEM_ARB_TIMEOUT_EN)
//
// Optional build macro: MEM_ARB_TIMEOUT_EN
//   Defined   : abort hung transactions, return rdata=0 with a valid pulse
//               and raise the sticky mem_timeout output.
//   Undefined : no timeout logic; a hung memory stalls the requester.
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int unsigned STARVE_LIMIT   = 4,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic               clk,
    input  logic               rst,
`ifdef MEM_ARB_TIMEOUT_EN
    output logic               mem_timeout,
`endif
    mem_port_arbiter_if.master bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        RESP = 2'd3
    } state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_DM = 1'b1
    } owner_t;

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_LIMIT);

    state_t      state_q;
    state_t      state_d;
    owner_t      owner_q;
    logic [3:0]  starve_q;

    logic        grant_if;
    logic        grant_dm;
    logic        capture;
    logic        abort;
    logic        timeout_hit;

    logic        mem_we_q;
    logic [3:0]  mem_be_q;
    logic [31:0] mem_addr_q;
    logic [31:0] mem_wdata_q;
    logic [31:0] if_rdata_q;
    logic [31:0] dm_rdata_q;

    // Next-state and arbitration
    always_comb begin
        state_d  = state_q;
        grant_if = 1'b0;
        grant_dm = 1'b0;
        capture  = 1'b0;
        abort    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.dm_req && (!bus.if_req || (starve_q < STARVE_LIM))) begin
                    grant_dm = 1'b1;
                    state_d  = ADDR;
                end else if (bus.if_req) begin
                    grant_if = 1'b1;
                    state_d  = ADDR;
                end
            end
            ADDR: begin
                // A stray mem_rvalid here belongs to nothing we issued.
                if (timeout_hit) begin
                    abort   = 1'b1;
                    state_d = RESP;
                end else if (bus.mem_gnt) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                // A response arriving on the last budget cycle still counts.
                if (bus.mem_rvalid) begin
                    capture = 1'b1;
                    state_d = RESP;
                end else if (timeout_hit) begin
                    abort   = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control state: FSM, owner, starvation counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            owner_q  <= OWN_IF;
            starve_q <= 4'd0;
        end else begin
            state_q <= state_d;
            if (grant_dm) begin
                owner_q <= OWN_DM;
            end else if (grant_if) begin
                owner_q <= OWN_IF;
            end
            if (state_q == IDLE) begin
                if (grant_if || !bus.if_req) begin
                    starve_q <= 4'd0;
                end else if (grant_dm && (starve_q != 4'hF)) begin
                    starve_q <= starve_q + 4'd1;
                end
            end
        end
    end

    // Request latch: held stable from grant through the end of ADDR
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_we_q    <= 1'b0;
            mem_be_q    <= 4'h0;
            mem_addr_q  <= 32'h0;
            mem_wdata_q <= 32'h0;
        end else if (grant_dm) begin
            mem_we_q    <= bus.dm_we;
            mem_be_q    <= bus.dm_be;
            mem_addr_q  <= bus.dm_addr;
            mem_wdata_q <= bus.dm_wdata;
        end else if (grant_if) begin
            // Fetches are always full-word reads.
            mem_we_q    <= 1'b0;
            mem_be_q    <= 4'hF;
            mem_addr_q  <= bus.if_addr;
            mem_wdata_q <= 32'h0;
        end
    end

    // Response capture: each requester's rdata holds until its next completion
    always_ff @(posedge clk) begin
        if (rst) begin
            if_rdata_q <= 32'h0;
            dm_rdata_q <= 32'h0;
        end else if (capture || abort) begin
            if (owner_q == OWN_DM) begin
                dm_rdata_q <= capture ? bus.mem_rdata : 32'h0;
            end else begin
                if_rdata_q <= capture ? bus.mem_rdata : 32'h0;
            end
        end
    end

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int unsigned TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    logic [TO_W-1:0] to_cnt_q;
    logic            timeout_q;

    // Budget counter: cleared on every grant (i.e. on entering ADDR), counts
    // each cycle spent in ADDR or DATA.
    always_ff @(posedge clk) begin
        if (rst) begin
            to_cnt_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (grant_if || grant_dm) begin
                to_cnt_q <= '0;
            end else if ((state_q == ADDR) || (state_q == DATA)) begin
                to_cnt_q <= to_cnt_q + 1'b1;
            end
            if (abort) begin
                timeout_q <= 1'b1;
            end
        end
    end

    assign timeout_hit = ((state_q == ADDR) || (state_q == DATA)) && (to_cnt_q == TO_LAST);
    assign mem_timeout = timeout_q;
`else
    // TIMEOUT_CYCLES only matters when the timeout logic is built in.
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^32'(TIMEOUT_CYCLES);
    assign timeout_hit        = 1'b0;
`endif

    // Outputs: all decoded from registers
    assign bus.mem_req   = (state_q == ADDR);
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_be    = mem_be_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;

    assign bus.if_valid  = (state_q == RESP) && (owner_q == OWN_IF);
    assign bus.dm_valid  = (state_q == RESP) && (owner_q == OWN_DM);
    assign bus.if_rdata  = if_rdata_q;
    assign bus.dm_rdata  = dm_rdata_q;

    assign bus.stall_if  = bus.if_req & ~bus.if_valid;
    assign bus.stall_dm  = bus.dm_req & ~bus.dm_valid;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares the single unified memory port between the instruction-fetch stage (IF requester) and the data-memory stage (DM requester).
- Serialises transactions through a req/gnt/rvalid handshake on the memory side.
- Returns each response to the requester that issued it.
- Drives stall_if / stall_dm into the hazard unit, which folds them into its stall_f / stall_if_id / stall_ex_dm controls.
- Data accesses have priority; a starvation counter guarantees fetch progress.

Parameters:
STARVE_LIMIT, 4, consecutive DM grants allowed while if_req is pending before IF is forced to win (1..15)
TIMEOUT_CYCLES, 255, cycles spent in ADDR+DATA before a transaction is aborted (used only with the optional feature)

Ports:
clk  in  1  core clock
rst  in  1  synchronous, active-high reset
if_req  in  1  fetch request; held with if_addr stable until if_valid
if_addr  in  32  fetch byte address
if_rdata  out  32  fetch data, valid with if_valid
if_valid  out  1  one-cycle fetch completion pulse
dm_req  in  1  data request; held with dm_* stable until dm_valid
dm_we  in  1  1 = store, 0 = load
dm_be  in  4  byte enables
dm_addr  in  32  data byte address
dm_wdata  in  32  store data
dm_rdata  out  32  load data, valid with dm_valid
dm_valid  out  1  one-cycle data completion pulse
mem_req  out  1  memory request
mem_we  out  1  memory write enable (0 for fetch)
mem_be  out  4  memory byte enables (4'hF for fetch)
mem_addr  out  32  memory address
mem_wdata  out  32  memory write data (0 for fetch)
mem_gnt  in  1  memory accepted request this cycle
mem_rvalid  in  1  memory response valid (loads and stores)
mem_rdata  in  32  memory read data
stall_if  out  1  if_req & ~if_valid (combinational)
stall_dm  out  1  dm_req & ~dm_valid (combinational)

Behaviour:
- FSM states IDLE, ADDR, DATA, RESP.
- Reset (sync, rst=1): state IDLE, owner=IF, starve_cnt=0. All mem_* outputs 0. if_valid=dm_valid=0, if_rdata=dm_rdata=0.
- IDLE arbitration:
  - If dm_req && (!if_req || starve_cnt < STARVE_LIMIT): owner=DM.
  - Else if if_req: owner=IF.
  - Else stay in IDLE.
  - On a grant, latch addr/we/be/wdata into mem_* registers and go to ADDR.
  - Fetch forces we=0, be=4'hF, wdata=0.
- starve_cnt:
  - Increments (saturating at 15) on each DM grant while if_req=1.
  - Clears on any IF grant, or when IDLE sees if_req=0.
- ADDR: mem_req=1. mem_* outputs stay stable until mem_gnt. On mem_gnt, go to DATA and drop mem_req on the next cycle. mem_rvalid is ignored in ADDR.
- DATA: mem_req=0. On mem_rvalid:
  - Register mem_rdata into the owner's rdata (stores also return mem_rdata).
  - Go to RESP.
- RESP:
  - Owner's valid=1 for exactly this cycle; the other requester's valid=0.
  - Next state IDLE, always.
  - No arbitration in RESP, so a still-high req in the pulse cycle is never re-issued.
- Minimum latency: req at cycle 0, mem_req at cycle 1, gnt at 1, rvalid at 2, valid at 3, IDLE at 4.
- rdata registers hold their value until the next completion for that requester.
- mem_rvalid seen in IDLE or RESP (stale, e.g. after reset) is ignored.
- Reset mid-transaction: next cycle IDLE, mem_req=0, no valid pulse. Requesters re-arbitrate from IDLE.
- Requester dropping req before valid is a protocol violation; behaviour is undefined and not checked.

Optional Feature:
Macro MEM_ARB_TIMEOUT_EN.
- Defined:
  - Adds output port mem_timeout (1 bit).
  - A counter runs while the FSM is in ADDR or DATA and clears on entering ADDR.
  - On reaching TIMEOUT_CYCLES, drop mem_req, force the owner's rdata=0 and go to RESP (valid pulse delivered).
  - mem_timeout sets sticky; it clears only on rst.
- Undefined: no counter and no port; a hung memory stalls forever.

Test Plan:
- Single fetch: if_req=1, if_addr=0x100; gnt at cycle 1, rvalid at cycle 2 with rdata=0x00000013. Expect:
  - mem_addr=0x100, mem_we=0, mem_be=0xF.
  - if_valid pulse at cycle 3, if_rdata=0x13.
  - stall_if=1 during cycles 0-2, 0 at cycle 3.
- Simultaneous requests: if_req and dm_req both 1 (store, dm_addr=0x2000, dm_wdata=0xDEADBEEF, be=0x3). Expect:
  - DM served first, with mem_we=1, mem_be=0x3.
  - IF issued right after DM's RESP; dm_valid precedes if_valid.
- Starvation: dm_req held high and re-asserted after every dm_valid, if_req held high, STARVE_LIMIT=4. Expect exactly 4 DM grants, then 1 IF grant, then the DM sequence resumes.
- Gnt back-pressure: mem_gnt low for 5 cycles. Expect mem_req=1 with mem_addr/we/be/wdata stable every cycle until gnt; exactly one transaction.
- Reset in DATA, then a stale mem_rvalid the next cycle. Expect:
  - mem_req=0 and no valid pulse.
  - The following if_req completes normally with correct data.
- (MEM_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8) mem_gnt never asserted. Expect dm_valid pulse with dm_rdata=0 and mem_timeout=1 that stays set until rst.
